// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM encoding, A-H letter codes, symbol table and timing thresholds.
// The symbol table is the same one the transmitter's pattern ROM is built from.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [2:0] L_A = 3'd0;
    localparam logic [2:0] L_B = 3'd1;
    localparam logic [2:0] L_C = 3'd2;
    localparam logic [2:0] L_D = 3'd3;
    localparam logic [2:0] L_E = 3'd4;
    localparam logic [2:0] L_F = 3'd5;
    localparam logic [2:0] L_G = 3'd6;
    localparam logic [2:0] L_H = 3'd7;

    localparam logic [2:0] DASH_UNITS       = 3'd2;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [2:0] MAX_SYMS         = 3'd4;
    localparam logic [2:0] CNT_OVF          = 3'd5;

    // Indexed by letter code; bit 0 holds the first symbol, dash = 1.
    localparam logic [2:0] SYM_LEN [8] = '{3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4};
    localparam logic [3:0] SYM_BITS[8] = '{4'b0010, 4'b0001, 4'b0101, 4'b0001,
                                           4'b0000, 4'b0100, 4'b0011, 4'b0000};

    // Returns {error, valid, code}; the overflow count 5 never matches a length.
    function automatic logic [4:0] lookup(input logic [2:0] cnt, input logic [3:0] sym);
        logic [4:0] r;
        logic [3:0] mask;
        r = 5'b10000;
        for (int i = 0; i < 8; i++) begin
            mask = 4'((5'd1 << SYM_LEN[i]) - 5'd1);
            if (cnt == SYM_LEN[i] && (sym & mask) == SYM_BITS[i])
                r = {1'b0, 1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: 2-FF synchronizer, stability-count debounce and 1-cycle edge pulses.
// The key is active-low; level and edges are reported in pressed=1 terms.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic level,
    output logic press_edge,
    output logic release_edge
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [DW-1:0] dcnt;
    logic          sample;

    assign sample = ~sync[1];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync         <= 2'b11;
            dcnt         <= '0;
            level        <= 1'b0;
            press_edge   <= 1'b0;
            release_edge <= 1'b0;
        end else begin
            sync         <= {sync[0], key_n};
            press_edge   <= 1'b0;
            release_edge <= 1'b0;
            if (sample == level) begin
                dcnt <= '0;
            end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                // Pulses are registered alongside the level so they line up with it.
                level        <= sample;
                dcnt         <= '0;
                press_edge   <= sample;
                release_edge <= ~sample;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times debounced presses/gaps in units, collects dots/dashes,
// and decodes the finished letter against the A-H table onto LEDR.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [1:0] KEY,
    output logic [9:0] LEDR
);

    localparam int CW = $clog2(UNIT_CYCLES + 1);

    logic          level, press_edge, release_edge;
    logic [CW-1:0] cyc;
    logic [2:0]    units;
    logic          tick;
    state_t        state;
    logic [3:0]    sym;
    logic [2:0]    cnt;
    logic [4:0]    result;
    logic          unused_key0;

    assign unused_key0 = KEY[0];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .key_n        (KEY[1]),
        .level        (level),
        .press_edge   (press_edge),
        .release_edge (release_edge)
    );

    assign tick = (cyc == CW'(UNIT_CYCLES - 1));

    // Any debounced edge restarts timing, taking priority over a coincident tick.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cyc   <= '0;
            units <= '0;
        end else if (press_edge || release_edge) begin
            cyc   <= '0;
            units <= '0;
        end else if (tick) begin
            cyc <= '0;
            if (units != 3'd7)
                units <= units + 3'd1;
        end else begin
            cyc <= cyc + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            sym    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (press_edge) state <= S_PRESS;
                S_PRESS: begin
                    if (release_edge) begin
                        if (cnt < MAX_SYMS)
                            sym[cnt[1:0]] <= (units >= DASH_UNITS);
                        if (cnt != CNT_OVF)
                            cnt <= cnt + 3'd1;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (press_edge)
                        state <= S_PRESS;
                    else if (tick && units == LETTER_GAP_UNITS - 3'd1)
                        state <= S_DONE;
                end
                S_DONE: begin
                    result <= lookup(cnt, sym);
                    sym    <= '0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign LEDR = {level, 1'b0, cnt, result};

endmodule
